// File: rtl/cache_cmd_arbiter.sv
// L1 cache command-port arbiter: snoop first, then I/D round-robin from small FIFOs,
// with issue/handshake sequencing and a start watchdog. Optional stats: CACHE_ARB_STATS_EN.

module cca_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wp, r_rp;
  logic [AW:0]             r_cnt;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end

  // Power-of-2 depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
endmodule

module cache_cmd_arbiter #(
  parameter int ADDR_W     = 60,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [2:0]        i_cmd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [2:0]        d_cmd,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [2:0]        s_cmd,
  input  logic [ADDR_W-1:0] s_addr,
  output logic              cache_write,
  output logic [2:0]        cache_command,
  output logic [ADDR_W-1:0] cache_address,
  input  logic              cache_processing,
  output logic              done,
  output logic [1:0]        done_id,
  output logic              busy,
  output logic              err_timeout
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt_i,
  output logic [31:0]       grant_cnt_d,
  output logic [31:0]       grant_cnt_s,
  output logic [15:0]       max_wait
`endif
);
  localparam int CW  = 3 + ADDR_W;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rr_d;
  logic [2:0]       r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]       r_id, r_done_id;
  logic [WDW-1:0]   r_wd;
  logic             r_err, r_done;
  logic             w_i_empty, w_i_full, w_d_empty, w_d_full;
  logic [CW-1:0]    w_i_head, w_d_head, w_sel;
  logic             w_gnt_i, w_gnt_d, w_gnt_s, w_grant;
  logic             w_wd_clr, w_wd_inc, w_to, w_done;

  cca_fifo #(.W(CW), .DEPTH(FIFO_DEPTH)) u_fifo_i (
    .clk, .rst_n, .i_push(i_valid && !w_i_full), .i_pop(w_gnt_i),
    .i_din({i_cmd, i_addr}), .o_dout(w_i_head), .o_empty(w_i_empty), .o_full(w_i_full)
  );

  cca_fifo #(.W(CW), .DEPTH(FIFO_DEPTH)) u_fifo_d (
    .clk, .rst_n, .i_push(d_valid && !w_d_full), .i_pop(w_gnt_d),
    .i_din({d_cmd, d_addr}), .o_dout(w_d_head), .o_empty(w_d_empty), .o_full(w_d_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    w_gnt_s     = 1'b0;
    cache_write = 1'b0;
    w_wd_clr    = 1'b0;
    w_wd_inc    = 1'b0;
    w_to        = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: if (!cache_processing) begin
        // Snoop always wins; r_rr_d picks D when both FIFOs hold work
        if (s_valid)                           w_gnt_s = 1'b1;
        else if (!w_i_empty && (w_d_empty || !r_rr_d)) w_gnt_i = 1'b1;
        else if (!w_d_empty)                   w_gnt_d = 1'b1;
        if (w_gnt_s || w_gnt_i || w_gnt_d) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        cache_write = 1'b1;
        w_wd_clr    = 1'b1;
        w_state_nxt = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (cache_processing) w_state_nxt = S_WAIT_DONE;
        else if (r_wd == WDW'(TIMEOUT - 1)) begin
          w_to        = 1'b1;
          w_state_nxt = S_ISSUE;
        end else w_wd_inc = 1'b1;
      end
      S_WAIT_DONE: if (!cache_processing) begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_grant = w_gnt_s || w_gnt_i || w_gnt_d;
  assign w_sel   = w_gnt_s ? {s_cmd, s_addr} : (w_gnt_i ? w_i_head : w_d_head);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rr_d    <= 1'b0;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_id      <= '0;
      r_wd      <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done;
      if (w_gnt_i) r_rr_d <= 1'b1;
      if (w_gnt_d) r_rr_d <= 1'b0;
      if (w_grant) begin
        {r_cmd, r_addr} <= w_sel;
        r_id            <= w_gnt_s ? 2'd2 : (w_gnt_d ? 2'd1 : 2'd0);
      end
      if (w_wd_clr)      r_wd <= '0;
      else if (w_wd_inc) r_wd <= r_wd + 1'b1;
      if (w_to)   r_err     <= 1'b1;
      if (w_done) r_done_id <= r_id;
    end
  end

  assign i_ready       = !w_i_full;
  assign d_ready       = !w_d_full;
  assign s_ready       = w_gnt_s;
  assign cache_command = r_cmd;
  assign cache_address = r_addr;
  assign done          = r_done;
  assign done_id       = r_done_id;
  assign busy          = (r_state != S_IDLE);
  assign err_timeout   = r_err;

`ifdef CACHE_ARB_STATS_EN
  logic [31:0] r_gc_i, r_gc_d, r_gc_s;
  logic [15:0] r_hw_i, r_hw_d, r_max, w_wait;

  assign w_wait = w_gnt_i ? r_hw_i : r_hw_d;

  // Head-wait counters restart whenever the head changes (pop) or the FIFO is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gc_i <= '0;
      r_gc_d <= '0;
      r_gc_s <= '0;
      r_hw_i <= '0;
      r_hw_d <= '0;
      r_max  <= '0;
    end else begin
      if (w_gnt_i && r_gc_i != '1) r_gc_i <= r_gc_i + 1'b1;
      if (w_gnt_d && r_gc_d != '1) r_gc_d <= r_gc_d + 1'b1;
      if (w_gnt_s && r_gc_s != '1) r_gc_s <= r_gc_s + 1'b1;
      if (w_gnt_i || w_i_empty)    r_hw_i <= '0;
      else if (r_hw_i != '1)       r_hw_i <= r_hw_i + 1'b1;
      if (w_gnt_d || w_d_empty)    r_hw_d <= '0;
      else if (r_hw_d != '1)       r_hw_d <= r_hw_d + 1'b1;
      if ((w_gnt_i || w_gnt_d) && w_wait > r_max) r_max <= w_wait;
    end
  end

  assign grant_cnt_i = r_gc_i;
  assign grant_cnt_d = r_gc_d;
  assign grant_cnt_s = r_gc_s;
  assign max_wait    = r_max;
`endif
endmodule

// File: tb/tb_cache_cmd_arbiter.sv
// Randomized + directed bench for cache_cmd_arbiter against a queue-based transaction model.
module tb_cache_cmd_arbiter;
  localparam int AW = 60, DEPTH = 4, TMO = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 0, d_valid = 0, s_valid = 0;
  logic i_ready, d_ready, s_ready;
  logic [2:0] i_cmd = 0, d_cmd = 0, s_cmd = 0;
  logic [AW-1:0] i_addr = 0, d_addr = 0, s_addr = 0;
  logic cache_write, cache_processing = 0, done, busy, err_timeout;
  logic [2:0] cache_command;
  logic [AW-1:0] cache_address;
  logic [1:0] done_id;

  always #5 clk = ~clk;

  cache_cmd_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_cmd(i_cmd), .i_addr(i_addr),
    .d_valid(d_valid), .d_ready(d_ready), .d_cmd(d_cmd), .d_addr(d_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd), .s_addr(s_addr),
    .cache_write(cache_write), .cache_command(cache_command), .cache_address(cache_address),
    .cache_processing(cache_processing), .done(done), .done_id(done_id),
    .busy(busy), .err_timeout(err_timeout)
  );

  typedef struct packed { logic [2:0] cmd; logic [AW-1:0] addr; } req_t;

  int n_chk = 0, n_fail = 0, cyc = 0;
  req_t qi[$], qd[$], cand, last_req;
  int glog[$];
  bit rr_d, outst, exp_wr, s_acc, g, no_resp, force_busy, start_req;
  int cand_id, last_id, last_wr_cyc, last_n, pn, rem;
  int wr_cnt = 0, done_cnt = 0, sr_cnt = 0, gnt_cyc, done_cyc;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Cache model: processing rises the cycle after the write strobe and lasts last_n cycles
  always @(posedge clk) begin
    #1;
    if (force_busy) cache_processing = 1;
    else if (start_req) begin start_req = 0; rem = last_n; cache_processing = 1; end
    else if (rem > 1) rem--;
    else begin rem = 0; cache_processing = 0; end
  end

  // Transaction model: FIFOs as queues, one command in flight, grant rule from the priority order
  always @(negedge clk) begin
    if (!rst_n) begin
      qi.delete(); qd.delete();
      rr_d = 0; outst = 0; exp_wr = 0; s_acc = 0;
    end else begin
      if (cache_write) begin
        wr_cnt++;
        if (outst) begin
          chk("retry_cmdaddr", {cache_command, cache_address}, last_req);
          chk("retry_gap", cyc - last_wr_cyc, TMO + 1);
          chk("retry_err", err_timeout, 1);
        end else begin
          chk("write_expected", exp_wr, 1);
          chk("issue_cmdaddr", {cache_command, cache_address}, cand);
          last_req = cand; last_id = cand_id; glog.push_back(cand_id);
          if (cand_id == 0) begin void'(qi.pop_front()); rr_d = 1; end
          else if (cand_id == 1) begin void'(qd.pop_front()); rr_d = 0; end
          outst = 1;
        end
        last_wr_cyc = cyc;
        if (!no_resp) begin start_req = 1; last_n = (pn == 0) ? $urandom_range(1, 3) : pn; end
      end else if (exp_wr) chk("write_missing", 0, 1);
      exp_wr = 0;
      if (done) begin
        done_cnt++;
        chk("done_outstanding", outst, 1);
        chk("done_id", done_id, last_id);
        chk("done_latency", cyc - last_wr_cyc, last_n + 2);
        outst = 0; done_cyc = cyc;
      end
      chk("busy", busy, outst);
      chk("i_ready", i_ready, qi.size() < DEPTH);
      chk("d_ready", d_ready, qd.size() < DEPTH);
      g = !outst && !cache_processing && (s_valid || qi.size() > 0 || qd.size() > 0);
      chk("s_ready", s_ready, g && s_valid);
      if (s_ready) begin s_acc = 1; sr_cnt++; end
      if (g) begin
        exp_wr = 1; gnt_cyc = cyc;
        if (s_valid) begin cand_id = 2; cand = {s_cmd, s_addr}; end
        else if (qi.size() > 0 && (qd.size() == 0 || !rr_d)) begin cand_id = 0; cand = qi[0]; end
        else begin cand_id = 1; cand = qd[0]; end
      end
      if (i_valid && qi.size() < DEPTH) qi.push_back({i_cmd, i_addr});
      if (d_valid && qd.size() < DEPTH) qd.push_back({d_cmd, d_addr});
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (s_acc) begin s_valid = 0; s_acc = 0; end
  endtask

  task automatic do_reset();
    rst_n = 0; i_valid = 0; d_valid = 0; s_valid = 0;
    force_busy = 0; no_resp = 0; start_req = 0; rem = 0; cache_processing = 0;
    repeat (2) tick();
    rst_n = 1; glog.delete();
    tick();
  endtask

  task automatic drain(int bound);
    int k = 0;
    bit idle = 0;
    while (!idle && k < bound) begin
      tick(); k++;
      idle = qi.size() == 0 && qd.size() == 0 && !outst && !exp_wr && !s_valid && !cache_processing;
    end
    if (!idle) chk("drain_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic rnd_req(output logic [2:0] c, output logic [AW-1:0] a);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    c = 3'($urandom_range(0, 4));
    a = r[AW-1:0];
  endtask

  int w0, d0, s0, k;
  int exp2[6] = '{0, 1, 0, 1, 0, 1};
  int exp3[5] = '{2, 0, 1, 0, 1};

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_i_ready", i_ready, 1);   chk("rst_d_ready", d_ready, 1);
    chk("rst_s_ready", s_ready, 0);   chk("rst_write", cache_write, 0);
    chk("rst_cmd", cache_command, 0); chk("rst_addr", cache_address, 0);
    chk("rst_done", done, 0);         chk("rst_done_id", done_id, 0);
    chk("rst_busy", busy, 0);         chk("rst_err", err_timeout, 0);
    rst_n = 1; tick();

    // Single I READ at 0x40, 2-cycle processing window
    pn = 2; w0 = wr_cnt;
    i_valid = 1; i_cmd = 0; i_addr = AW'(64'h40);
    tick(); i_valid = 0;
    drain(100);
    chk("t1_writes", wr_cnt - w0, 1);
    chk("t1_id", glog.size() == 1 ? glog[0] : -1, 0);
    chk("t1_grant_to_done", done_cyc - gnt_cyc, 5);

    // Three I and three D at once alternate from I
    do_reset(); pn = 0;
    repeat (3) begin
      i_valid = 1; d_valid = 1; rnd_req(i_cmd, i_addr); rnd_req(d_cmd, d_addr); tick();
    end
    i_valid = 0; d_valid = 0;
    drain(200);
    chk("t2_count", glog.size(), 6);
    for (int j = 0; j < 6; j++) chk("t2_order", j < glog.size() ? glog[j] : -1, exp2[j]);
    chk("t2_i_ready", i_ready, 1); chk("t2_d_ready", d_ready, 1);

    // Snoop jumps ahead of populated FIFOs without moving the pointer
    do_reset(); force_busy = 1; s0 = sr_cnt; tick(); tick();
    repeat (2) begin
      i_valid = 1; d_valid = 1; rnd_req(i_cmd, i_addr); rnd_req(d_cmd, d_addr); tick();
    end
    i_valid = 0; d_valid = 0;
    s_valid = 1; s_cmd = 3'd2; s_addr = AW'(64'h1234);
    tick(); force_busy = 0;
    drain(200);
    chk("t3_sready_pulses", sr_cnt - s0, 1);
    chk("t3_count", glog.size(), 5);
    for (int j = 0; j < 5; j++) chk("t3_order", j < glog.size() ? glog[j] : -1, exp3[j]);

    // Fill I FIFO while the cache is busy; fifth push must be dropped
    do_reset(); force_busy = 1; tick(); tick();
    for (int j = 0; j < 4; j++) begin
      chk("t4_ready_before", i_ready, 1);
      i_valid = 1; i_cmd = 3'(j); i_addr = AW'(64'h100 + j); tick();
    end
    chk("t4_full", i_ready, 0);
    i_addr = AW'(64'hdead); tick(); i_valid = 0;
    chk("t4_still_full", i_ready, 0);
    force_busy = 0;
    drain(200);
    chk("t4_grants", glog.size(), 4);

    // Cache never starts: watchdog fires and the same command is re-strobed
    do_reset(); no_resp = 1; w0 = wr_cnt;
    d_valid = 1; d_cmd = 3'd1; d_addr = AW'(64'hbeef0); tick(); d_valid = 0;
    k = 0;
    while (wr_cnt - w0 < 2 && k < 80) begin tick(); k++; end
    chk("t5_restrobe_seen", wr_cnt - w0, 2);
    chk("t5_err", err_timeout, 1);
    no_resp = 0;
    drain(100);
    chk("t5_writes", wr_cnt - w0, 3);
    chk("t5_err_sticky", err_timeout, 1);
    do_reset();
    chk("t5_err_cleared", err_timeout, 0);

    // Reset during WAIT_DONE abandons the command
    pn = 2; w0 = wr_cnt;
    i_valid = 1; i_cmd = 3'd4; i_addr = AW'(64'h80); tick(); i_valid = 0;
    k = 0;
    while (wr_cnt == w0 && k < 20) begin tick(); k++; end
    chk("t6_issued", wr_cnt - w0, 1);
    tick();
    chk("t6_in_wait_done", busy && cache_processing, 1);
    d0 = done_cnt;
    rst_n = 0; start_req = 0; rem = 0; cache_processing = 0;
    #1;
    chk("t6_busy", busy, 0);     chk("t6_done", done, 0);
    chk("t6_cmd", cache_command, 0); chk("t6_addr", cache_address, 0);
    chk("t6_i_ready", i_ready, 1);
    repeat (2) tick();
    rst_n = 1;
    repeat (6) tick();
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_idle", busy, 0);

    // Random traffic
    do_reset(); pn = 0;
    repeat (400) begin
      i_valid = ($urandom_range(0, 2) == 0); rnd_req(i_cmd, i_addr);
      d_valid = ($urandom_range(0, 2) == 0); rnd_req(d_cmd, d_addr);
      if (!s_valid && $urandom_range(0, 15) == 0) begin s_valid = 1; rnd_req(s_cmd, s_addr); end
      tick();
    end
    i_valid = 0; d_valid = 0;
    drain(400);
    chk("rand_no_err", err_timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/cache_cmd_arbiter.md
Name: cache_cmd_arbiter

Overview:
- Shares the single command port of the L1 cache between three requesters: instruction fetch (I), data (D) and snoop (S).
- Buffers I and D requests in small FIFOs and selects one request per slot: S has fixed priority, then I and D alternate round-robin.
- Sequences each command through the cache's write/processing handshake and reports completion.
- Sits between the trace/CPU front end and the cache.

Parameters:
- ADDR_W, 60, address width; matches the cache address port.
- FIFO_DEPTH, 4, entries per I and D FIFO; must be a power of 2, at least 2.
- TIMEOUT, 16, max cycles to wait for cache_processing to rise after issue.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  instruction request valid.
- i_ready  out  1  I FIFO not full.
- i_cmd  in  3  cache command code (READ=0 WRITE=1 INVALIDATE=2 CLEAR=3 L2DATAREQUEST=4).
- i_addr  in  ADDR_W  request address.
- d_valid  in  1  data request valid.
- d_ready  out  1  D FIFO not full.
- d_cmd  in  3  command code.
- d_addr  in  ADDR_W  address.
- s_valid  in  1  snoop request valid; no FIFO.
- s_ready  out  1  snoop accepted this cycle.
- s_cmd  in  3  command code.
- s_addr  in  ADDR_W  address.
- cache_write  out  1  one-cycle issue strobe to the cache.
- cache_command  out  3  issued command.
- cache_address  out  ADDR_W  issued address.
- cache_processing  in  1  cache busy flag.
- done  out  1  one-cycle pulse when a command completes.
- done_id  out  2  requester of the completed command: 0=I, 1=D, 2=S.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky flag: cache did not start a command.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; FIFOs empty; round-robin pointer = I. All outputs 0 except i_ready=1 and d_ready=1. err_timeout cleared.
- Reset mid-command abandons the command; no done pulse is produced.
- FIFOs: push when valid && ready. Ready = !full (registered count). Simultaneous push and pop on a full FIFO is not allowed: ready is already low. Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: leave only when cache_processing=0 and some request is pending. Select in this order: S if s_valid; otherwise the round-robin winner of the non-empty I/D FIFOs. Latch cmd/addr/id into an issue register. Pop the chosen FIFO, or pulse s_ready for one cycle. Flip the round-robin pointer to the other of I/D only when I or D was granted. Go to ISSUE.
  - ISSUE: cache_write=1 for exactly 1 cycle, with cache_command/cache_address held from the issue register. Go to WAIT_START and clear the watchdog.
  - WAIT_START: when cache_processing=1, go to WAIT_DONE. Otherwise increment the watchdog. At TIMEOUT cycles: set err_timeout, return to ISSUE and re-strobe the same command.
  - WAIT_DONE: when cache_processing=0, pulse done with done_id for 1 cycle and return to IDLE.
- cache_command/cache_address hold their last value outside ISSUE. cache_write is 0 in every state except ISSUE.
- Minimum latency: IDLE select → ISSUE (+1 cycle) → cache latches the command → processing high (+2) → done. With a 2-cycle processing window (READ with LRU update), done is 5 cycles after the grant.
- Back-to-back commands: IDLE re-arbitrates in the cycle after done.
- Snoop starvation of I/D is accepted as a design decision.

Optional Feature:
- Macro: CACHE_ARB_STATS_EN.
- With the macro defined, the block adds:
  - Three 32-bit saturating grant counters: grant_cnt_i, grant_cnt_d, grant_cnt_s. Each increments in the IDLE grant cycle, is reset to 0, and is exposed as an output port.
  - A 16-bit output max_wait: the largest number of cycles any I/D head entry waited between becoming head and being granted.
- Without the macro, these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Single I READ at addr 0x40, cache model asserts processing 2 cycles → exactly one cache_write with cmd=0 addr=0x40; done with done_id=0 at cycle 5 after grant.
- I and D each push 3 requests at once → grant order I,D,I,D,I,D; i_ready/d_ready return to 1 once the FIFOs drain.
- s_valid asserted while both FIFOs are non-empty → S granted next (done_id=2); s_ready pulses once; round-robin pointer unchanged.
- Push 4 entries to I with no pops → i_ready=0 after the 4th; a 5th push with i_valid=1 is dropped (count stays 4).
- Cache model never raises processing → after 16 cycles err_timeout=1 and cache_write re-pulses with the same cmd/addr.
- rst_n driven low during WAIT_DONE → all outputs immediately reset; no done; FIFO count=0.
